// File: rtl/uart_rx_buffer_pkg.sv
// Shared definitions for the UART receive buffer.
// Holds the request FSM state encoding, the pop size codes and the
// default FIFO depth (log2, in bytes).
package uart_rx_buffer_pkg;

  localparam int DEFAULT_DEPTH_LOG2 = 4;

  localparam logic RD_BYTE = 1'b0;
  localparam logic RD_WORD = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } req_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Circular byte FIFO: one byte written per cycle, up to four bytes popped
// per cycle. The four bytes starting at the read pointer are always
// presented on head_word (oldest in [7:0]) so a byte or word pop can be
// registered by the caller without extra latency.
// Ports:
//   clk, rst       clock, async active-high reset (pointers and count only)
//   push/push_data write one byte at the write pointer
//   pop/pop_word   remove 1 byte (pop_word=0) or 4 bytes (pop_word=1)
//   head_word      four bytes at the read pointer, little-endian
//   count          bytes currently stored
// The caller guarantees push only when space exists and pop only when
// enough bytes are stored.
module uart_byte_fifo
  import uart_rx_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [7:0]            push_data,
  input  logic                  pop,
  input  logic                  pop_word,
  output logic [31:0]           head_word,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = (DEPTH_LOG2)'(1);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   pop_n;
  logic [DEPTH_LOG2-1:0] rd_idx [4];

  always_comb begin
    pop_n = '0;
    if (pop) begin
      pop_n = pop_word ? (DEPTH_LOG2+1)'(4) : (DEPTH_LOG2+1)'(1);
    end
  end

  // Index arithmetic is DEPTH_LOG2 bits wide, so a word read straddling
  // the end of storage wraps to the start on its own.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rd_idx[i] = rd_ptr + (DEPTH_LOG2)'(i);
    end
  end

  assign head_word = {mem[rd_idx[3]], mem[rd_idx[2]], mem[rd_idx[1]], mem[rd_idx[0]]};

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      // A pop of 4 with DEPTH_LOG2 == 2 truncates to 0, which is the
      // correct advance modulo the depth.
      rd_ptr <= rd_ptr + pop_n[DEPTH_LOG2-1:0];
      count  <= count + {{DEPTH_LOG2{1'b0}}, push} - pop_n;
    end
  end

endmodule

// File: rtl/uart_rx_buffer.sv
// UART receive buffer: requests bytes from the UART wrapper while space
// remains, stores every received byte in a byte FIFO, and lets the CPU or
// loader pop one byte (zero-extended) or one little-endian word per request.
// Ports:
//   clk, rst          clock, async active-high reset
//   u_ready           UART wrapper can accept a read request
//   rx_done, r_data   received byte strobe and data (may be unsolicited)
//   r_valid           one-cycle registered read request
//   rd_req, rd_size   pop request, 0 = byte, 1 = word
//   rd_ready          enough bytes buffered for rd_size
//   rd_valid, rd_data popped data, one cycle after an accepted rd_req
//   count             bytes buffered
//   overflow, ovf_clr sticky dropped-byte flag and its clear
//
// state   | meaning
// IDLE    | no request outstanding; request when idle UART and space left
// REQ     | r_valid is high this cycle
// WAIT    | request issued, waiting for rx_done
module uart_rx_buffer
  import uart_rx_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  u_ready,
  input  logic                  rx_done,
  input  logic [7:0]            r_data,
  output logic                  r_valid,
  input  logic                  rd_req,
  input  logic                  rd_size,
  output logic                  rd_ready,
  output logic                  rd_valid,
  output logic [31:0]           rd_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  input  logic                  ovf_clr
);

  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0] WORD_CNT  = (DEPTH_LOG2+1)'(4);

  req_state_t  state;
  req_state_t  state_next;
  logic        req_next;
  logic        pop;
  logic        push;
  logic        drop;
  logic [31:0] head_word;

  assign rd_ready = (rd_size == RD_BYTE) ? (count != '0) : (count >= WORD_CNT);
  assign pop      = rd_req && rd_ready;
  // A full FIFO still accepts the byte when a pop frees space this cycle.
  assign push     = rx_done && ((count != DEPTH_CNT) || pop);
  assign drop     = rx_done && !push;

  uart_byte_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (r_data),
    .pop       (pop),
    .pop_word  (rd_size),
    .head_word (head_word),
    .count     (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      r_valid <= 1'b0;
    end else begin
      state   <= state_next;
      r_valid <= req_next;
    end
  end

  // Leaving IDLE implies no request is outstanding, so buffered bytes
  // alone decide whether space remains.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (u_ready && (count < DEPTH_CNT)) state_next = ST_REQ;
      ST_REQ:  state_next = ST_WAIT;
      ST_WAIT: if (rx_done) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_next = (state_next == ST_REQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      overflow <= 1'b0;
    end else begin
      rd_valid <= pop;
      if (pop) begin
        rd_data <= (rd_size == RD_WORD) ? head_word : {24'h0, head_word[7:0]};
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_buffer.sv
module tb_uart_rx_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        u_ready = 1'b0;
  logic        rx_done = 1'b0;
  logic [7:0]  r_data = 8'h00;
  logic        rd_req = 1'b0;
  logic        rd_size = 1'b0;
  logic        ovf_clr = 1'b0;
  logic        r_valid;
  logic        rd_ready;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [4:0]  count;
  logic        overflow;

  int total = 0;
  int bad = 0;

  // Reference model: byte queue, registered pop data and sticky flag.
  bit [7:0]    q[$];
  logic [31:0] m_data;
  bit          m_ovf;
  bit          exp_ready;
  bit          exp_valid;

  logic        obs_ready, obs_rvalid, obs_valid, obs_ovf;
  logic [31:0] obs_data;
  logic [4:0]  obs_count;

  uart_rx_buffer dut (
    .clk      (clk),
    .rst      (rst),
    .u_ready  (u_ready),
    .rx_done  (rx_done),
    .r_data   (r_data),
    .r_valid  (r_valid),
    .rd_req   (rd_req),
    .rd_size  (rd_size),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .count    (count),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    q.delete();
    m_data = '0;
    m_ovf = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    u_ready = 1'b0; rx_done = 1'b0; rd_req = 1'b0; ovf_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Drives one cycle of inputs, advances the model by the same cycle and
  // captures DUT outputs: rd_ready/r_valid before the edge, the rest after.
  task automatic drive_cycle(input bit rx, input bit [7:0] d, input bit req,
                             input bit sz, input bit clr);
    bit drop;
    int pop_n;
    rx_done = rx; r_data = d; rd_req = req; rd_size = sz; ovf_clr = clr;
    #1;
    obs_ready = rd_ready;
    obs_rvalid = r_valid;
    exp_ready = sz ? (q.size() >= 4) : (q.size() >= 1);
    exp_valid = 1'b0;
    if (req && exp_ready) begin
      pop_n = sz ? 4 : 1;
      m_data = '0;
      for (int i = 0; i < pop_n; i++) m_data[8*i +: 8] = q.pop_front();
      exp_valid = 1'b1;
    end
    drop = rx && (q.size() >= 16);
    if (rx && !drop) q.push_back(d);
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    @(posedge clk);
    #1;
    rx_done = 1'b0; rd_req = 1'b0; ovf_clr = 1'b0;
    obs_valid = rd_valid;
    obs_data = rd_data;
    obs_count = count;
    obs_ovf = overflow;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++; if (r_valid !== 1'b0) begin bad++; $display("FAIL reset_r_valid got=%0b want=0", r_valid); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%0b want=0", rd_valid); end
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL reset_rd_data got=%h want=0", rd_data); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0b want=0", overflow); end
    do_reset();
  endtask

  task automatic test_request();
    bit seen;
    do_reset();
    u_ready = 1'b1;
    drive_cycle(0, 8'h00, 0, 0, 0);
    total++; if (r_valid !== 1'b1) begin bad++; $display("FAIL req_pulse got=%0b want=1", r_valid); end
    drive_cycle(0, 8'h00, 0, 0, 0);
    seen = r_valid;
    repeat (5) begin
      drive_cycle(0, 8'h00, 0, 0, 0);
      seen |= r_valid;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL req_single got=%0b want=0", seen); end
    drive_cycle(1, 8'h41, 0, 0, 0);
    total++; if (obs_count !== 5'd1) begin bad++; $display("FAIL req_push_count got=%0d want=1", obs_count); end
    drive_cycle(0, 8'h00, 0, 0, 0);
    total++; if (r_valid !== 1'b1) begin bad++; $display("FAIL req_again got=%0b want=1", r_valid); end
    u_ready = 1'b0;
  endtask

  task automatic test_word_pop();
    do_reset();
    drive_cycle(1, 8'h11, 0, 0, 0);
    drive_cycle(1, 8'h22, 0, 0, 0);
    drive_cycle(1, 8'h33, 0, 0, 0);
    drive_cycle(1, 8'h44, 0, 0, 0);
    drive_cycle(0, 8'h00, 1, 1, 0);
    total++; if (obs_valid !== 1'b1) begin bad++; $display("FAIL word_valid got=%0b want=1", obs_valid); end
    total++; if (obs_data !== 32'h44332211) begin bad++; $display("FAIL word_data got=%h want=44332211", obs_data); end
    total++; if (obs_count !== 5'd0) begin bad++; $display("FAIL word_count got=%0d want=0", obs_count); end
  endtask

  task automatic test_not_ready();
    do_reset();
    drive_cycle(1, 8'h11, 0, 0, 0);
    drive_cycle(1, 8'h22, 0, 0, 0);
    drive_cycle(1, 8'h33, 0, 0, 0);
    drive_cycle(0, 8'h00, 1, 1, 0);
    total++; if (obs_ready !== 1'b0) begin bad++; $display("FAIL nr_ready got=%0b want=0", obs_ready); end
    total++; if (obs_valid !== 1'b0) begin bad++; $display("FAIL nr_valid got=%0b want=0", obs_valid); end
    total++; if (obs_count !== 5'd3) begin bad++; $display("FAIL nr_count got=%0d want=3", obs_count); end
    drive_cycle(0, 8'h00, 1, 0, 0);
    total++; if (obs_ready !== 1'b1) begin bad++; $display("FAIL nr_byte_ready got=%0b want=1", obs_ready); end
    total++; if (obs_data !== 32'h00000011) begin bad++; $display("FAIL nr_byte_data got=%h want=00000011", obs_data); end
  endtask

  task automatic test_full_overflow();
    bit pend;
    bit seen;
    do_reset();
    u_ready = 1'b1;
    pend = 1'b0;
    for (int i = 0; i < 300 && q.size() < 16; i++) begin
      drive_cycle(pend, 8'(i + 8'h60), 0, 0, 0);
      pend = obs_rvalid;
    end
    total++; if (obs_count !== 5'd16) begin bad++; $display("FAIL fill_count got=%0d want=16", obs_count); end
    seen = 1'b0;
    repeat (10) begin
      drive_cycle(0, 8'h00, 0, 0, 0);
      seen |= obs_rvalid | r_valid;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL full_no_req got=%0b want=0", seen); end
    drive_cycle(1, 8'hEE, 0, 0, 0);
    total++; if (obs_ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0b want=1", obs_ovf); end
    total++; if (obs_count !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d want=16", obs_count); end
    drive_cycle(1, 8'hEF, 0, 0, 1);
    total++; if (obs_ovf !== 1'b1) begin bad++; $display("FAIL ovf_set_prio got=%0b want=1", obs_ovf); end
    drive_cycle(0, 8'h00, 0, 0, 1);
    total++; if (obs_ovf !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%0b want=0", obs_ovf); end
    drive_cycle(1, 8'h5A, 1, 0, 0);
    total++; if (obs_ovf !== 1'b0) begin bad++; $display("FAIL full_pushpop_ovf got=%0b want=0", obs_ovf); end
    total++; if (obs_count !== 5'd16) begin bad++; $display("FAIL full_pushpop_count got=%0d want=16", obs_count); end
    total++; if (obs_data !== m_data) begin bad++; $display("FAIL full_pushpop_data got=%h want=%h", obs_data, m_data); end
    u_ready = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 14; i++) drive_cycle(1, 8'(i), 0, 0, 0);
    for (int i = 0; i < 14; i++) drive_cycle(0, 8'h00, 1, 0, 0);
    drive_cycle(1, 8'hA0, 0, 0, 0);
    drive_cycle(1, 8'hA1, 0, 0, 0);
    drive_cycle(1, 8'hA2, 0, 0, 0);
    drive_cycle(1, 8'hA3, 0, 0, 0);
    drive_cycle(0, 8'h00, 1, 1, 0);
    total++; if (obs_data !== 32'hA3A2A1A0) begin bad++; $display("FAIL wrap_data got=%h want=A3A2A1A0", obs_data); end
    total++; if (obs_count !== 5'd0) begin bad++; $display("FAIL wrap_count got=%0d want=0", obs_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 5; i++) drive_cycle(1, 8'(8'h51 + i), 0, 0, 0);
    drive_cycle(1, 8'h99, 1, 0, 0);
    total++; if (obs_count !== 5'd5) begin bad++; $display("FAIL simul_count got=%0d want=5", obs_count); end
    total++; if (obs_data !== 32'h00000051) begin bad++; $display("FAIL simul_data got=%h want=00000051", obs_data); end
  endtask

  task automatic test_reset_wait();
    bit found;
    do_reset();
    drive_cycle(1, 8'h31, 0, 0, 0);
    drive_cycle(1, 8'h32, 0, 0, 0);
    drive_cycle(1, 8'h33, 0, 0, 0);
    drive_cycle(0, 8'h00, 1, 0, 0);
    u_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      drive_cycle(0, 8'h00, 0, 0, 0);
      found = obs_rvalid;
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL rstw_req_timeout got=%0b want=1", found); end
    #2 rst = 1'b1;
    #1;
    total++; if (r_valid !== 1'b0) begin bad++; $display("FAIL rstw_r_valid got=%0b want=0", r_valid); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL rstw_count got=%0d want=0", count); end
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL rstw_rd_data got=%h want=0", rd_data); end
    u_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    drive_cycle(1, 8'h77, 0, 0, 0);
    total++; if (obs_count !== 5'd1) begin bad++; $display("FAIL late_rx_count got=%0d want=1", obs_count); end
    drive_cycle(0, 8'h00, 1, 0, 0);
    total++; if (obs_data !== 32'h00000077) begin bad++; $display("FAIL late_rx_data got=%h want=00000077", obs_data); end
  endtask

  task automatic test_random();
    bit outstanding;
    bit rx, rq, sz, clr;
    do_reset();
    outstanding = 1'b0;
    for (int i = 0; i < 600; i++) begin
      u_ready = ($urandom_range(0, 3) != 0);
      rx  = (i < 300) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
      rq  = (i < 300) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 6);
      sz  = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 15) == 0);
      drive_cycle(rx, 8'($urandom), rq, sz, clr);
      total++; if (obs_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%0b want=%0b", i, obs_ready, exp_ready); end
      total++; if (obs_valid !== exp_valid) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%0b want=%0b", i, obs_valid, exp_valid); end
      total++; if (obs_data !== m_data) begin bad++; $display("FAIL rnd_data cyc=%0d got=%h want=%h", i, obs_data, m_data); end
      total++; if (obs_count !== 5'(q.size())) begin bad++; $display("FAIL rnd_count cyc=%0d got=%0d want=%0d", i, obs_count, q.size()); end
      total++; if (obs_ovf !== m_ovf) begin bad++; $display("FAIL rnd_ovf cyc=%0d got=%0b want=%0b", i, obs_ovf, m_ovf); end
      if (obs_rvalid) begin
        total++; if (outstanding) begin bad++; $display("FAIL rnd_second_req cyc=%0d got=1 want=0", i); end
        outstanding = 1'b1;
      end else if (rx) begin
        outstanding = 1'b0;
      end
    end
    u_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_request();
    test_word_pop();
    test_not_ready();
    test_full_overflow();
    test_wrap();
    test_back_to_back();
    test_reset_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_buffer.md
Name: uart_rx_buffer

Overview:
Receive-side consumer of the UART wrapper. It issues read requests (r_valid) to the UART wrapper whenever buffer space exists, and captures each received byte into a circular byte FIFO. The CPU/loader side pops either one byte or one little-endian 32-bit word per request. This decouples the slow AXI UART Lite polling from the core's memory-mapped I/O and the program loader.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth in bytes (DEPTH = 16); must be >= 2 so that a full word fits.

Ports:
clk  in  1  system clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
u_ready  in  1  UART wrapper idle and able to accept a request
rx_done  in  1  one-cycle pulse; r_data holds a valid received byte
r_data  in  8  received byte from UART wrapper
r_valid  out  1  one-cycle read request to UART wrapper
rd_req  in  1  CPU pop request, sampled each cycle
rd_size  in  1  0 = pop 1 byte, 1 = pop 4 bytes (word)
rd_ready  out  1  combinational: enough bytes buffered for the current rd_size
rd_valid  out  1  one-cycle pulse: rd_data valid
rd_data  out  32  popped data
count  out  DEPTH_LOG2+1  bytes currently buffered
overflow  out  1  sticky: byte dropped because FIFO full
ovf_clr  in  1  clears overflow

Behaviour:
- Reset values: r_valid=0, rd_valid=0, rd_data=0, count=0, overflow=0; pointers=0; FSM=IDLE. FIFO RAM contents are not reset.
- Request FSM, states IDLE, REQ, WAIT:
  - IDLE->REQ when u_ready && (count + pending pushes) < DEPTH.
  - REQ: r_valid=1 for exactly one cycle, then ->WAIT.
  - WAIT->IDLE on rx_done.
  - At most one outstanding request; r_valid is registered.
- Push: every rx_done writes r_data at wr_ptr; wr_ptr += 1 mod DEPTH.
  - rx_done arriving in any state, including unsolicited, is accepted if count < DEPTH.
  - If count == DEPTH (after accounting for a same-cycle pop), the byte is dropped and overflow is set.
- Pop:
  - rd_ready = (rd_size==0) ? count>=1 : count>=4.
  - When rd_req && rd_ready: bytes are read at rd_ptr and rd_ptr advances by 1 or 4 mod DEPTH. rd_data and rd_valid are registered and appear the next cycle (latency 1).
  - Word pop is little-endian: the oldest byte goes to rd_data[7:0], the newest to [31:24].
  - Byte pop zero-extends into rd_data.
  - rd_req while !rd_ready is ignored: no pop, rd_valid stays 0, no error.
  - rd_data holds its last value when rd_valid=0.
- Simultaneous push and pop in the same cycle: both take effect; count_next = count + push − popped_n.
  - A pop never reads the byte being written that cycle; readiness uses the pre-update count.
- Wrap-around: pointers are DEPTH_LOG2 bits and wrap naturally; a word pop may straddle the wrap (e.g. rd_ptr = DEPTH−2).
- overflow: set on a drop, cleared by ovf_clr. Set has priority if both occur in the same cycle.
- Reset mid-operation (e.g. in WAIT): reset is asynchronous and returns FSM, pointers, count and flags to their reset values immediately. A late rx_done after reset release is treated as an unsolicited push.

Decomposition:
- Shared package holds FSM state encoding (IDLE/REQ/WAIT), RD_BYTE/RD_WORD size constants, and the default DEPTH_LOG2.
- One sub-module: uart_byte_fifo. It contains the storage, pointers and count, with a 1-write/4-wide-read port and a pop amount of 1 or 4.
- The request FSM and pop control live in the top level.

Test Plan:
- Reset, then u_ready=1 -> r_valid pulses 1 cycle; no second pulse until rx_done; rx_done with r_data=0x41 -> count=1.
- Push 0x11,0x22,0x33,0x44; rd_req, rd_size=1 -> next cycle rd_valid=1, rd_data=0x44332211, count=0.
- count=3, rd_req with rd_size=1 -> rd_ready=0, no rd_valid, count stays 3; then rd_size=0 -> rd_data=0x00000011 (oldest byte).
- Fill 16 bytes -> FSM stops requesting; extra unsolicited rx_done -> overflow=1, count=16; ovf_clr -> overflow=0.
- Advance pointers to 14, push 4 bytes 0xA0..0xA3, word pop -> rd_data=0xA3A2A1A0 across the wrap.
- Same-cycle rx_done and byte pop at count=5 -> count stays 5, popped byte is the oldest; assert rst during WAIT -> r_valid=0, count=0 immediately.
